// File: rtl/clkdiv_pkg.sv
// clkdiv_pkg: shared types, widths and helpers for the multi-channel clock divider
package clkdiv_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        PEND = 1'b1
    } pend_state_e;

    localparam int CLKDIV_TICKCNT_W = 8;

    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/clkdiv_multi_if.sv
// clkdiv_multi_if: run-control, config handshake and divided outputs of clkdiv_multi
// CLKDIV_MULTI_TICKCNT_EN adds the per-channel tick_cnt bus.
interface clkdiv_multi_if #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 16,
    parameter int CH_W   = clkdiv_pkg::clog2_min1(NUM_CH)
);
    logic [NUM_CH-1:0] ch_en;
    logic              sync_req;
    logic              cfg_valid;
    logic              cfg_ready;
    logic [CH_W-1:0]   cfg_ch;
    logic [CNT_W-1:0]  cfg_div;
    logic [NUM_CH-1:0] tick;
    logic [NUM_CH-1:0] clk_out;
`ifdef CLKDIV_MULTI_TICKCNT_EN
    logic [NUM_CH*clkdiv_pkg::CLKDIV_TICKCNT_W-1:0] tick_cnt;

    modport master (
        output ch_en, sync_req, cfg_valid, cfg_ch, cfg_div,
        input  cfg_ready, tick, clk_out, tick_cnt
    );

    modport slave (
        input  ch_en, sync_req, cfg_valid, cfg_ch, cfg_div,
        output cfg_ready, tick, clk_out, tick_cnt
    );
`else
    modport master (
        output ch_en, sync_req, cfg_valid, cfg_ch, cfg_div,
        input  cfg_ready, tick, clk_out
    );

    modport slave (
        input  ch_en, sync_req, cfg_valid, cfg_ch, cfg_div,
        output cfg_ready, tick, clk_out
    );
`endif
endinterface

// File: rtl/clkdiv_chan.sv
// clkdiv_chan: one divider channel with glitch-free divide reload
// CLKDIV_MULTI_TICKCNT_EN adds an 8-bit wrapping tick counter.
module clkdiv_chan
    import clkdiv_pkg::*;
#(
    parameter int CNT_W       = 16,
    parameter int DEFAULT_DIV = 12
) (
    input  logic             clk_in,
    input  logic             Reset,
    input  logic             i_en,
    input  logic             i_sync,
    input  logic             i_acc,
    input  logic [CNT_W-1:0] i_cfg_div,
    output pend_state_e      o_pend,
    output logic             o_tick,
    output logic             o_clk_out
`ifdef CLKDIV_MULTI_TICKCNT_EN
    ,
    output logic [CLKDIV_TICKCNT_W-1:0] o_tick_cnt
`endif
);

    logic [CNT_W-1:0] r_cnt, r_div, r_nxt_div;
    logic [CNT_W-1:0] w_cnt, w_div, w_nxt_div;
    pend_state_e      r_pend, w_pend;
    logic             r_tick, r_clk_out;
    logic             w_tick, w_clk_out, w_term, w_swap;

    assign w_term = r_cnt == r_div;
    // No period is running past this cycle, so a new div cannot shorten one
    assign w_swap = i_sync | ~i_en | w_term;

    always_ff @(posedge clk_in) begin
        if (Reset) begin
            r_cnt     <= '0;
            r_div     <= CNT_W'(DEFAULT_DIV);
            r_nxt_div <= '0;
            r_pend    <= IDLE;
            r_tick    <= 1'b0;
            r_clk_out <= 1'b0;
        end else begin
            r_cnt     <= w_cnt;
            r_div     <= w_div;
            r_nxt_div <= w_nxt_div;
            r_pend    <= w_pend;
            r_tick    <= w_tick;
            r_clk_out <= w_clk_out;
        end
    end

    always_comb begin
        w_tick    = ~i_sync & i_en & w_term;
        w_cnt     = i_sync ? '0 : (i_en ? (w_term ? '0 : r_cnt + 1'b1) : r_cnt);
        w_clk_out = i_sync ? 1'b0 : r_clk_out ^ w_tick;
        w_pend    = w_swap ? IDLE : (i_acc ? PEND : r_pend);
        w_nxt_div = (~w_swap & i_acc) ? i_cfg_div : r_nxt_div;
        w_div     = (w_swap & i_acc) ? i_cfg_div :
                    ((w_swap & (r_pend == PEND)) ? r_nxt_div : r_div);
    end

    assign o_pend    = r_pend;
    assign o_tick    = r_tick;
    assign o_clk_out = r_clk_out;

`ifdef CLKDIV_MULTI_TICKCNT_EN
    logic [CLKDIV_TICKCNT_W-1:0] r_tick_cnt;

    always_ff @(posedge clk_in) begin
        if (Reset || i_sync) r_tick_cnt <= '0;
        else                 r_tick_cnt <= r_tick_cnt + CLKDIV_TICKCNT_W'(w_tick);
    end

    assign o_tick_cnt = r_tick_cnt;
`endif

endmodule

// File: rtl/clkdiv_multi.sv
// clkdiv_multi: NUM_CH runtime-programmable clock dividers sharing one config port
// CLKDIV_MULTI_TICKCNT_EN adds per-channel 8-bit tick counters on the interface.
module clkdiv_multi
    import clkdiv_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int CNT_W       = 16,
    parameter int DEFAULT_DIV = 12
) (
    input logic            clk_in,
    input logic            Reset,
    clkdiv_multi_if.slave  bus
);

    localparam int CH_W = clog2_min1(NUM_CH);

    // Unused decode slots read as IDLE so out-of-range requests are accepted and dropped
    pend_state_e       w_pend [2**CH_W];
    logic [NUM_CH-1:0] w_acc;

    assign bus.cfg_ready = ~Reset & (w_pend[bus.cfg_ch] == IDLE);

    genvar i;
    for (i = 0; i < 2**CH_W; i++) begin : g_ch
        if (i < NUM_CH) begin : g_act
            assign w_acc[i] = bus.cfg_valid & bus.cfg_ready & (bus.cfg_ch == CH_W'(i));

            clkdiv_chan #(
                .CNT_W       (CNT_W),
                .DEFAULT_DIV (DEFAULT_DIV)
            ) u_chan (
                .clk_in     (clk_in),
                .Reset      (Reset),
                .i_en       (bus.ch_en[i]),
                .i_sync     (bus.sync_req),
                .i_acc      (w_acc[i]),
                .i_cfg_div  (bus.cfg_div),
                .o_pend     (w_pend[i]),
                .o_tick     (bus.tick[i]),
                .o_clk_out  (bus.clk_out[i])
`ifdef CLKDIV_MULTI_TICKCNT_EN
                ,
                .o_tick_cnt (bus.tick_cnt[i*CLKDIV_TICKCNT_W +: CLKDIV_TICKCNT_W])
`endif
            );
        end else begin : g_pad
            assign w_pend[i] = IDLE;
        end
    end

endmodule

// File: tb/tb_clkdiv_multi.sv
// tb_clkdiv_multi: directed scenarios plus randomized traffic against a tick-counting reference model
module tb_clkdiv_multi;

    localparam int NCH = 4;

    logic clk_in = 1'b0;
    logic Reset  = 1'b1;
    int   checks = 0;
    int   failures = 0;

    clkdiv_multi_if #(.NUM_CH(NCH), .CNT_W(16)) bus ();

    clkdiv_multi #(.NUM_CH(NCH), .CNT_W(16), .DEFAULT_DIV(12)) dut (
        .clk_in (clk_in),
        .Reset  (Reset),
        .bus    (bus)
    );

    always #5 clk_in = ~clk_in;

    // Reference: count position, active period, queued reload, ticks since last clear
    int          m_cnt   [NCH];
    int          m_div   [NCH];
    int          m_ticks [NCH];
    int          m_q     [NCH][$];
    logic [NCH-1:0] m_tick;

    function automatic logic [NCH-1:0] m_clk();
        logic [NCH-1:0] v;
        for (int c = 0; c < NCH; c++) v[c] = (m_ticks[c] % 2) == 1;
        return v;
    endfunction

    function automatic logic m_ready();
        return !Reset && (m_q[bus.cfg_ch].size() == 0);
    endfunction

    always @(posedge clk_in) begin
        int acc;
        bit term;
        if (Reset) begin
            for (int c = 0; c < NCH; c++) begin
                m_cnt[c] = 0; m_div[c] = 12; m_ticks[c] = 0; m_q[c].delete();
            end
            m_tick = '0;
        end else begin
            acc = (bus.cfg_valid && m_q[bus.cfg_ch].size() == 0) ? int'(bus.cfg_ch) : -1;
            for (int c = 0; c < NCH; c++) begin
                term = bus.ch_en[c] && (m_cnt[c] == m_div[c]);
                m_tick[c] = term && !bus.sync_req;
                if (bus.sync_req || !bus.ch_en[c] || term) begin
                    if (m_q[c].size() > 0) m_div[c] = m_q[c].pop_front();
                    if (acc == c) m_div[c] = int'(bus.cfg_div);
                end else if (acc == c) begin
                    m_q[c].push_back(int'(bus.cfg_div));
                end
                if (bus.sync_req) begin
                    m_cnt[c] = 0; m_ticks[c] = 0;
                end else if (m_tick[c]) begin
                    m_cnt[c] = 0; m_ticks[c]++;
                end else if (bus.ch_en[c]) begin
                    m_cnt[c] = (m_cnt[c] + 1) % 65536;
                end
            end
        end
    end

    task automatic test_reset();
        Reset = 1'b1; bus.ch_en = '0; bus.sync_req = 1'b0;
        bus.cfg_valid = 1'b0; bus.cfg_ch = '0; bus.cfg_div = '0;
        repeat (3) @(negedge clk_in);
        checks++;
        if (bus.tick !== '0 || bus.clk_out !== '0) begin
            failures++; $display("FAIL reset_out: tick=%b clk_out=%b expected 0", bus.tick, bus.clk_out);
        end
        checks++;
        if (bus.cfg_ready !== 1'b0) begin
            failures++; $display("FAIL reset_ready: got %b expected 0", bus.cfg_ready);
        end
        Reset = 1'b0;
        @(negedge clk_in);
        checks++;
        if (bus.cfg_ready !== 1'b1) begin
            failures++; $display("FAIL ready_after_reset: got %b expected 1", bus.cfg_ready);
        end
    endtask

    task automatic test_default_div();
        int first = -1, nt = 0, hi = 0, oth = 0;
        bus.ch_en = 4'b0001;
        for (int n = 1; n <= 60; n++) begin
            @(negedge clk_in);
            if (bus.tick[0] === 1'b1) begin nt++; if (first < 0) first = n; end
            if (bus.clk_out[0] === 1'b1) hi++;
            if (bus.tick[3:1] !== 3'b0 || bus.clk_out[3:1] !== 3'b0) oth++;
            checks++;
            if (bus.tick !== m_tick || bus.clk_out !== m_clk()) begin
                failures++;
                $display("FAIL default_model n=%0d: tick=%b clk=%b expected tick=%b clk=%b",
                         n, bus.tick, bus.clk_out, m_tick, m_clk());
            end
        end
        checks++; if (first != 13) begin failures++; $display("FAIL first_tick: got %0d expected 13", first); end
        checks++; if (nt != 4)     begin failures++; $display("FAIL tick_count: got %0d expected 4", nt); end
        checks++; if (hi != 26)    begin failures++; $display("FAIL clk_high: got %0d expected 26", hi); end
        checks++; if (oth != 0)    begin failures++; $display("FAIL idle_channels: got %0d active cycles expected 0", oth); end
    endtask

    task automatic test_div0();
        logic prev;
        bus.cfg_valid = 1'b1; bus.cfg_ch = 2'd1; bus.cfg_div = 16'd0;
        #1;
        checks++;
        if (bus.cfg_ready !== 1'b1) begin
            failures++; $display("FAIL div0_ready: got %b expected 1", bus.cfg_ready);
        end
        @(negedge clk_in);
        bus.cfg_valid = 1'b0; bus.ch_en = 4'b0011;
        prev = bus.clk_out[1];
        for (int n = 1; n <= 8; n++) begin
            @(negedge clk_in);
            checks++;
            if (bus.tick[1] !== 1'b1 || bus.clk_out[1] === prev) begin
                failures++;
                $display("FAIL div0 n=%0d: tick1=%b clk1=%b expected tick1=1 clk1=%b",
                         n, bus.tick[1], bus.clk_out[1], ~prev);
            end
            prev = bus.clk_out[1];
        end
    endtask

    task automatic test_reload();
        int k = 0, gap;
        for (int n = 0; n < 20 && m_cnt[0] != 5; n++) @(negedge clk_in);
        checks++;
        if (m_cnt[0] != 5) begin failures++; $display("FAIL reload_wait: cnt %0d expected 5", m_cnt[0]); end
        bus.cfg_valid = 1'b1; bus.cfg_ch = 2'd0; bus.cfg_div = 16'd3;
        @(negedge clk_in);
        bus.cfg_valid = 1'b0;
        checks++;
        if (bus.cfg_ready !== 1'b0) begin failures++; $display("FAIL reload_busy: got %b expected 0", bus.cfg_ready); end
        k = 1;
        while (bus.tick[0] !== 1'b1 && k < 20) begin @(negedge clk_in); k++; end
        checks++;
        if (k != 8) begin failures++; $display("FAIL reload_period: tick after %0d expected 8", k); end
        checks++;
        if (bus.cfg_ready !== 1'b1) begin failures++; $display("FAIL reload_ready: got %b expected 1", bus.cfg_ready); end
        for (int p = 0; p < 2; p++) begin
            gap = 0;
            do begin @(negedge clk_in); gap++; end while (bus.tick[0] !== 1'b1 && gap < 20);
            checks++;
            if (gap != 4) begin failures++; $display("FAIL reload_new_period %0d: got %0d expected 4", p, gap); end
        end
    endtask

    task automatic test_sync();
        int k;
        bus.cfg_valid = 1'b1; bus.cfg_ch = 2'd2; bus.cfg_div = 16'd7;
        @(negedge clk_in);
        bus.cfg_valid = 1'b0; bus.ch_en = 4'b0101;
        for (int n = 0; n < 20 && m_cnt[2] != 4; n++) @(negedge clk_in);
        checks++;
        if (m_cnt[2] != 4) begin failures++; $display("FAIL sync_wait: cnt %0d expected 4", m_cnt[2]); end
        bus.sync_req = 1'b1;
        @(negedge clk_in);
        bus.sync_req = 1'b0;
        checks++;
        if (bus.clk_out !== '0 || bus.tick !== '0) begin
            failures++; $display("FAIL sync_clear: clk_out=%b tick=%b expected 0", bus.clk_out, bus.tick);
        end
        k = 0;
        do begin @(negedge clk_in); k++; end while (bus.tick[2] !== 1'b1 && k < 20);
        checks++;
        if (k != 8) begin failures++; $display("FAIL sync_first_tick: got %0d expected 8", k); end
    endtask

    task automatic test_reset_pending();
        int k;
        for (int n = 0; n < 10 && m_cnt[0] != 1; n++) @(negedge clk_in);
        bus.cfg_valid = 1'b1; bus.cfg_ch = 2'd0; bus.cfg_div = 16'd9;
        @(negedge clk_in);
        bus.cfg_valid = 1'b0;
        checks++;
        if (bus.cfg_ready !== 1'b0) begin failures++; $display("FAIL pend_before_reset: got %b expected 0", bus.cfg_ready); end
        Reset = 1'b1; bus.ch_en = 4'b0001;
        @(negedge clk_in);
        checks++;
        if (bus.tick !== '0 || bus.clk_out !== '0 || bus.cfg_ready !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid: tick=%b clk=%b ready=%b expected 0 0 0", bus.tick, bus.clk_out, bus.cfg_ready);
        end
        Reset = 1'b0;
        k = 0;
        do begin @(negedge clk_in); k++; end while (bus.tick[0] !== 1'b1 && k < 30);
        checks++;
        if (k != 13) begin failures++; $display("FAIL reset_discard: tick after %0d expected 13", k); end
        checks++;
        if (bus.cfg_ready !== 1'b1) begin failures++; $display("FAIL reset_ready_idle: got %b expected 1", bus.cfg_ready); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 1500; n++) begin
            @(negedge clk_in);
            checks++;
            if (bus.tick !== m_tick || bus.clk_out !== m_clk() || bus.cfg_ready !== m_ready()) begin
                failures++;
                $display("FAIL random n=%0d: tick=%b clk=%b rdy=%b expected tick=%b clk=%b rdy=%b",
                         n, bus.tick, bus.clk_out, bus.cfg_ready, m_tick, m_clk(), m_ready());
            end
`ifdef CLKDIV_MULTI_TICKCNT_EN
            for (int c = 0; c < NCH; c++) begin
                checks++;
                if (bus.tick_cnt[8*c +: 8] !== 8'(m_ticks[c] % 256)) begin
                    failures++;
                    $display("FAIL random_tick_cnt ch%0d: got %0d expected %0d", c, bus.tick_cnt[8*c +: 8], m_ticks[c] % 256);
                end
            end
`endif
            Reset         = ($urandom_range(399) == 0);
            bus.sync_req  = ($urandom_range(99) == 0);
            bus.cfg_valid = ($urandom_range(3) == 0);
            bus.cfg_ch    = 2'($urandom_range(NCH - 1));
            bus.cfg_div   = 16'($urandom_range(9));
            if ($urandom_range(19) == 0) bus.ch_en = 4'($urandom);
        end
        Reset = 1'b0; bus.sync_req = 1'b0; bus.cfg_valid = 1'b0;
    endtask

`ifdef CLKDIV_MULTI_TICKCNT_EN
    task automatic test_tickcnt();
        Reset = 1'b1; bus.ch_en = '0;
        @(negedge clk_in);
        Reset = 1'b0;
        bus.cfg_valid = 1'b1; bus.cfg_ch = 2'd3; bus.cfg_div = 16'd0;
        @(negedge clk_in);
        bus.cfg_valid = 1'b0; bus.ch_en = 4'b1000;
        repeat (300) @(negedge clk_in);
        bus.ch_en = '0;
        checks++;
        if (bus.tick_cnt[31:24] !== 8'd44) begin
            failures++; $display("FAIL tick_cnt_wrap: got %0d expected 44", bus.tick_cnt[31:24]);
        end
    endtask
`endif

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_default_div();
        test_div0();
        test_reload();
        test_sync();
        test_reset_pending();
        test_random();
`ifdef CLKDIV_MULTI_TICKCNT_EN
        test_tickcnt();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/clkdiv_multi.md
Name: clkdiv_multi

Overview:
- Multi-channel, runtime-programmable clock divider and strobe generator. Successor to the fixed single-channel toggle divider.
- Each channel produces a one-cycle enable pulse `tick` and a 50% duty divided clock `clk_out`.
- Divide values are reloadable through a valid/ready config port without glitching the output.
- Feeds CPU, PPU and timer clock-enables (e.g. the timer's selectable 4096/16384/65536/262144 Hz rates) from one fast system clock.

Parameters:
- NUM_CH, 4, number of independent channels (1..16).
- CNT_W, 16, counter and divide-value width in bits.
- DEFAULT_DIV, 12, terminal count loaded into every channel on reset (must fit in CNT_W).

Ports:
- clk_in  in  1  system clock; all logic on posedge.
- Reset  in  1  synchronous, active-high reset.
- ch_en  in  NUM_CH  per-channel run enable.
- sync_req  in  1  phase-realign all channels.
- cfg_valid  in  1  config request valid.
- cfg_ready  out  1  config request can be accepted.
- cfg_ch  in  max(1,$clog2(NUM_CH))  target channel.
- cfg_div  in  CNT_W  new terminal count.
- tick  out  NUM_CH  registered one-cycle pulse per channel period.
- clk_out  out  NUM_CH  registered divided clock, toggles at each tick.

Behaviour:
- Reset (sync, active-high) sets every channel:
  - cnt=0, div=DEFAULT_DIV, pend=IDLE.
  - tick=0, clk_out=0.
  - cfg_ready=1 one cycle after Reset deasserts. cfg_ready=0 while Reset is high.
  - Reset mid-operation discards any pending config.
- Channel counting with ch_en[i]=1:
  - If cnt==div: cnt<=0, tick[i]<=1 (next cycle), clk_out[i]<=~clk_out[i].
  - Otherwise cnt<=cnt+1 and tick[i]<=0.
- Periods:
  - tick period = div+1 cycles; clk_out period = 2*(div+1).
  - First tick occurs div+1 cycles after enable from cnt=0.
  - Latency from terminal count to tick/clk_out is 1 cycle (both registered).
  - div=0: tick high every cycle and clk_out toggles every cycle.
  - Counter arithmetic is unsigned CNT_W; cnt never exceeds div, so no wrap occurs.
- ch_en[i]=0: cnt, clk_out[i] and div hold; tick[i]=0. On re-enable, counting resumes from the held cnt.
- Config handshake:
  - A request is accepted when cfg_valid & cfg_ready.
  - cfg_ready = ~Reset & (pend[cfg_ch]==IDLE).
  - cfg_ch >= NUM_CH: the request is accepted (ready=1) and ignored.
- Per-channel pend FSM, states IDLE and PEND, with a shadow register nxt_div:
  - IDLE -> PEND on accept while ch_en=1 and cnt!=div; nxt_div<=cfg_div.
  - IDLE stays IDLE on accept when the channel is disabled: div<=cfg_div directly, cnt unchanged.
  - IDLE stays IDLE on accept at terminal count (ch_en=1, cnt==div): div<=cfg_div directly. The new value governs the period starting that cycle.
  - PEND -> IDLE at next terminal count: div<=nxt_div and cnt<=0.
  - PEND -> IDLE on sync_req: div<=nxt_div.
  - PEND -> IDLE when ch_en drops: div<=nxt_div.
  - The new div never truncates a period in progress, so no runt clk_out pulses occur.
- sync_req=1 (priority below Reset, above counting):
  - All channels get cnt<=0, clk_out<=0, tick<=0.
  - Pending values are applied.
  - A config accepted in the same cycle is written to div directly.
- Independence: channels never interact except through sync_req and the shared config port.

Optional Feature:
- Macro: CLKDIV_MULTI_TICKCNT_EN.
- Defined:
  - Adds output tick_cnt (NUM_CH*8 bits, channel i in bits [8i+7:8i]).
  - Each 8-bit field increments on every tick of its channel and wraps 255->0.
  - Cleared by Reset and sync_req.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Package clkdiv_pkg holds:
  - pend_state_e enum (IDLE, PEND).
  - Localparam CLKDIV_TICKCNT_W=8.
  - Function clog2_min1 for the cfg_ch width.
- Sub-module clkdiv_chan implements one channel: cnt, div, nxt_div, pend FSM, tick/clk_out registers, optional tick counter.
- The top level does only generate-loop instantiation, cfg_ch decode and cfg_ready mux.

Test Plan:
- Reset then ch_en=4'b0001, DEFAULT_DIV=12 -> tick[0] every 13 cycles; clk_out[0] period 26 cycles, 13 high / 13 low; other channels stay 0.
- cfg write ch1 div=0 while ch1 disabled, then enable -> tick[1] high every cycle; clk_out[1] toggles every cycle from the first enabled cycle+1.
- Ch0 running with div=12 at cnt=5: write div=3 -> cfg_ready low for ch0; current period completes at 13 cycles; following ticks every 4 cycles; cfg_ready high after the swap.
- Ch2 div=7 mid-period (cnt=4): pulse sync_req -> all clk_out=0 and cnt=0; next tick[2] exactly 8 cycles later.
- Assert Reset for 1 cycle with a ch0 write pending -> next period uses div=12; tick=0 and clk_out=0 the cycle after Reset.
- With CLKDIV_MULTI_TICKCNT_EN, ch3 div=0 for 300 cycles -> tick_cnt[31:24]==300 mod 256 = 44.
